// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU) for the EX stage: one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN adds a magnitude compare that finishes trivial quotients at once.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall_req,
  output logic             ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  typedef enum logic [1:0] {StIdle, StOn, StEnd} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Holds the dividend magnitude; quotient bits shift in at the LSB as it empties.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] result_lo_q, result_lo_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;

  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   partial, diff;
  logic [WIDTH-1:0] dvd_step, rem_step;
  logic             early_out;
  logic             q_neg_in, r_neg_in;

  assign q_neg_in = signed_en & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  assign r_neg_in = signed_en & dividend[WIDTH-1];
  assign abs_dvd  = r_neg_in ? -dividend : dividend;
  assign abs_dvs  = (signed_en && divisor[WIDTH-1]) ? -divisor : divisor;

  // Partial remainder is always below the divisor, so WIDTH+1 bits hold both the
  // shifted value and the sign of the trial difference.
  assign partial  = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = partial - {1'b0, dvs_q};
  assign dvd_step = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_step = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (dividend == '0) || (abs_dvs > abs_dvd);
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    stall_req   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          stall_req = 1'b1;
          dvd_d     = abs_dvd;
          dvs_d     = abs_dvs;
          rem_d     = '0;
          cnt_d     = '0;
          q_neg_d   = q_neg_in;
          r_neg_d   = r_neg_in;
          if (divisor == '0) begin
            // Divide-by-zero resolves here so ready lands in the next cycle; no sign fix-up.
            result_lo_d = '1;
            result_hi_d = dividend;
            state_d     = StEnd;
          end else if (early_out) begin
            result_lo_d = '0;
            result_hi_d = r_neg_in ? -abs_dvd : abs_dvd;
            state_d     = StEnd;
          end else begin
            state_d = StOn;
          end
        end
      end

      StOn: begin
        stall_req = 1'b1;
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          dvd_d = dvd_step;
          rem_d = rem_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            result_lo_d = q_neg_q ? -dvd_step : dvd_step;
            result_hi_d = r_neg_q ? -rem_step : rem_step;
            state_d     = StEnd;
          end
        end
      end

      StEnd: begin
        // Commit point: cancel is deliberately ignored here.
        state_d = StIdle;
        cnt_d   = '0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
    end
  end

  assign ready     = (state_q == StEnd);
  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a 32-bit and an 8-bit instance driven with directed vectors.
module tb_div_unit;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    int          t0;
    int          lat;
  } exp_t;

`ifdef DIV_EARLY_OUT_EN
  localparam int EoLat = 1;
`else
  localparam int EoLat = 33;
`endif

  logic        clk = 1'b0;
  logic        reset_a, start_a, sgn_a, cancel_a;
  logic [31:0] dvd_a, dvs_a;
  logic        stall_a, ready_a;
  logic [31:0] lo_a, hi_a;

  logic        reset_b, start_b, sgn_b, cancel_b;
  logic [7:0]  dvd_b, dvs_b;
  logic        stall_b, ready_b;
  logic [7:0]  lo_b, hi_b;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  div_unit #(.WIDTH(32)) dut_a (
    .clk      (clk),
    .reset    (reset_a),
    .start    (start_a),
    .signed_en(sgn_a),
    .dividend (dvd_a),
    .divisor  (dvs_a),
    .cancel   (cancel_a),
    .stall_req(stall_a),
    .ready    (ready_a),
    .result_lo(lo_a),
    .result_hi(hi_a)
  );

  div_unit #(.WIDTH(8)) dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .start    (start_b),
    .signed_en(sgn_b),
    .dividend (dvd_b),
    .divisor  (dvs_b),
    .cancel   (cancel_b),
    .stall_req(stall_b),
    .ready    (ready_b),
    .result_lo(lo_b),
    .result_hi(hi_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start is high for one cycle (cycle 0); returns at the start of cycle 1.
  task automatic issue(input bit sel, input bit sgn, input logic [31:0] dvd,
                       input logic [31:0] dvs, input int lat, input logic [31:0] elo,
                       input logic [31:0] ehi, input bit push, input string name);
    exp_t e;
    next_cycle();
    if (!sel) begin
      start_a = 1'b1; sgn_a = sgn; dvd_a = dvd; dvs_a = dvs;
    end else begin
      start_b = 1'b1; sgn_b = sgn; dvd_b = dvd[7:0]; dvs_b = dvs[7:0];
    end
    e.name = name; e.lo = elo; e.hi = ehi; e.t0 = cyc; e.lat = lat;
    if (push) begin
      if (!sel) q_a.push_back(e);
      else q_b.push_back(e);
    end
    @(negedge clk);
    check({name, "_stall_c0"}, sel ? stall_b : stall_a, 1);
    next_cycle();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    next_cycle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ready_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready_a: got ready=1 lo=%0h hi=%0h expected no ready (cycle %0d)",
                 lo_a, hi_a, cyc);
      end else begin
        e = q_a.pop_front();
        check({e.name, "_lo"}, lo_a, e.lo);
        check({e.name, "_hi"}, hi_a, e.hi);
        check({e.name, "_lat"}, cyc - e.t0, e.lat);
        check({e.name, "_stall_rdy"}, stall_a, 0);
      end
    end
    if (ready_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready_b: got ready=1 lo=%0h hi=%0h expected no ready (cycle %0d)",
                 lo_b, hi_b, cyc);
      end else begin
        e = q_b.pop_front();
        check({e.name, "_lo"}, {24'd0, lo_b}, e.lo);
        check({e.name, "_hi"}, {24'd0, hi_b}, e.hi);
        check({e.name, "_lat"}, cyc - e.t0, e.lat);
        check({e.name, "_stall_rdy"}, stall_b, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by time 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset_a = 1'b1; start_a = 1'b0; sgn_a = 1'b0; cancel_a = 1'b0; dvd_a = '0; dvs_a = '0;
    reset_b = 1'b1; start_b = 1'b0; sgn_b = 1'b0; cancel_b = 1'b0; dvd_b = '0; dvs_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", ready_a, 0);
    check("rst_a_stall", stall_a, 0);
    check("rst_a_lo", lo_a, 0);
    check("rst_a_hi", hi_a, 0);
    check("rst_b_ready", ready_b, 0);
    check("rst_b_lo", {24'd0, lo_b}, 0);
    check("rst_b_hi", {24'd0, hi_b}, 0);
    next_cycle();
    reset_a = 1'b0;
    reset_b = 1'b0;

    // 100 / 7 unsigned, with stall_req tracked through every cycle.
    issue(0, 0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1, "u100_7");
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check($sformatf("u100_7_stall_c%0d", k), stall_a, 1);
    end
    @(negedge clk);
    check("u100_7_stall_c33", stall_a, 0);
    wait_idle();

    issue(0, 1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, "s_m7_2");
    wait_idle();
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1, "s_ovf");
    wait_idle();
    issue(0, 0, 32'd200, 32'd9, 33, 32'd22, 32'd2, 1, "u200_9");
    wait_idle();

    issue(0, 0, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1, "dz_u");
    wait_idle();
    issue(0, 1, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, "dz_s");
    wait_idle();

    // Cancel in cycle 10: no ready, results hold.
    issue(0, 0, 32'd100, 32'd7, 0, 0, 0, 0, "cancel_on");
    repeat (9) next_cycle();
    cancel_a = 1'b1;
    next_cycle();
    cancel_a = 1'b0;
    @(negedge clk);
    check("cancel_stall_c11", stall_a, 0);
    check("cancel_lo_hold", lo_a, 32'hFFFF_FFFF);
    check("cancel_hi_hold", hi_a, 32'hFFFF_FFF9);
    repeat (40) next_cycle();

    // Start pulse in cycle 5 of a running op is ignored.
    issue(0, 0, 32'd200, 32'd9, 33, 32'd22, 32'd2, 1, "ign_start");
    repeat (4) next_cycle();
    start_a = 1'b1; dvd_a = 32'd50; dvs_a = 32'd5;
    next_cycle();
    start_a = 1'b0;
    wait_idle();
    repeat (40) next_cycle();

    // Start with cancel in IDLE is dropped.
    next_cycle();
    start_a = 1'b1; cancel_a = 1'b1; sgn_a = 1'b0; dvd_a = 32'd9; dvs_a = 32'd3;
    @(negedge clk);
    check("start_cancel_stall", stall_a, 0);
    next_cycle();
    start_a = 1'b0; cancel_a = 1'b0;
    repeat (40) next_cycle();

    // Cancel in END still yields ready.
    issue(0, 0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1, "cancel_end");
    repeat (32) next_cycle();
    cancel_a = 1'b1;
    next_cycle();
    cancel_a = 1'b0;
    wait_idle();

    issue(0, 0, 32'd3, 32'd10, EoLat, 32'd0, 32'd3, 1, "eo_u3_10");
    wait_idle();
    issue(0, 1, 32'hFFFF_FFFD, 32'd10, EoLat, 32'd0, 32'hFFFF_FFFD, 1, "eo_s_m3_10");
    wait_idle();

    // 8-bit instance.
    issue(1, 0, 32'hFF, 32'h10, 9, 32'h0F, 32'h0F, 1, "w8_ff_10");
    wait_idle();
    issue(1, 1, 32'h80, 32'hFF, 9, 32'h80, 32'h00, 1, "w8_s_ovf");
    wait_idle();
    issue(1, 0, 32'hFF, 32'h10, 0, 0, 0, 0, "w8_reset");
    repeat (3) next_cycle();
    reset_b = 1'b1;
    next_cycle();
    reset_b = 1'b0;
    @(negedge clk);
    check("w8_rst_stall", stall_b, 0);
    check("w8_rst_ready", ready_b, 0);
    check("w8_rst_lo", {24'd0, lo_b}, 0);
    check("w8_rst_hi", {24'd0, hi_b}, 0);
    repeat (20) next_cycle();

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
